// File: rtl/dds_segment_scheduler_if.sv
// Segment-scheduler bus: iteration pulse and chaotic state from the generator
// side, and the load strobe plus per-channel segment parameters to the DDS side.
interface dds_segment_scheduler_if #(
    parameter int PHASE_WIDTH      = 32,
    parameter int PERIOD_NUM_WIDTH = 3
);
    logic                        chaotic_ctrl;
    logic                        ch0_chaotic_valid;
    logic [PHASE_WIDTH-1:0]      ch0_chaotic_x;
    logic [PHASE_WIDTH-1:0]      ch0_chaotic_y;
    logic [PHASE_WIDTH-1:0]      ch0_chaotic_z;
    logic                        ch1_chaotic_valid;
    logic [PHASE_WIDTH-1:0]      ch1_chaotic_x;
    logic [PHASE_WIDTH-1:0]      ch1_chaotic_y;
    logic [PHASE_WIDTH-1:0]      ch1_chaotic_z;
    logic                        seg_ready;
    logic                        seg_load;
    logic [PERIOD_NUM_WIDTH-1:0] ch0_period_num;
    logic [PHASE_WIDTH-1:0]      ch0_phase_init;
    logic [PHASE_WIDTH-1:0]      ch0_phase_end;
    logic [PERIOD_NUM_WIDTH-1:0] ch1_period_num;
    logic [PHASE_WIDTH-1:0]      ch1_phase_init;
    logic [PHASE_WIDTH-1:0]      ch1_phase_end;

    // Scheduler side
    modport master (
        output chaotic_ctrl, seg_load,
        output ch0_period_num, ch0_phase_init, ch0_phase_end,
        output ch1_period_num, ch1_phase_init, ch1_phase_end,
        input  ch0_chaotic_valid, ch0_chaotic_x, ch0_chaotic_y, ch0_chaotic_z,
        input  ch1_chaotic_valid, ch1_chaotic_x, ch1_chaotic_y, ch1_chaotic_z,
        input  seg_ready
    );

    // Generator / DDS side
    modport slave (
        input  chaotic_ctrl, seg_load,
        input  ch0_period_num, ch0_phase_init, ch0_phase_end,
        input  ch1_period_num, ch1_phase_init, ch1_phase_end,
        output ch0_chaotic_valid, ch0_chaotic_x, ch0_chaotic_y, ch0_chaotic_z,
        output ch1_chaotic_valid, ch1_chaotic_x, ch1_chaotic_y, ch1_chaotic_z,
        output seg_ready
    );
endinterface

// File: rtl/dds_segment_scheduler.sv
// Demand-driven segment scheduler for the two-channel chaotic DDS: pulses the
// chaotic generator, captures both channels' state into a one-deep prefetch
// buffer, and loads both DDS channels together once the DDS side is ready.
module dds_segment_scheduler #(
    parameter int PHASE_WIDTH      = 32,
    parameter int PERIOD_NUM_WIDTH = 3,
    parameter int TIMEOUT_WIDTH    = 16,
    parameter int SEG_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     ch0_mod,
    input  logic                     ch1_mod,
    dds_segment_scheduler_if.master  bus,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [SEG_CNT_WIDTH-1:0] seg_count
);
    localparam int PW  = PHASE_WIDTH;
    localparam int PNW = PERIOD_NUM_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, LOAD} state_t;

    state_t                   state;
    logic [1:0]               got;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic                     to_en;

    // Prefetch buffer holds already-derived parameters, so mod is applied at capture
    logic [1:0][PNW-1:0] buf_pn;
    logic [1:0][PW-1:0]  buf_pi;
    logic [1:0][PW-1:0]  buf_pe;

    logic [1:0]          vld, mods, take, got_nxt;
    logic [1:0][PW-1:0]  cx, cy, cz;
    logic [1:0][PNW-1:0] der_pn;
    logic [1:0][PW-1:0]  der_pi, der_pe;
    logic                unused_x_lsbs;

    assign vld  = {bus.ch1_chaotic_valid, bus.ch0_chaotic_valid};
    assign mods = {ch1_mod, ch0_mod};
    assign cx   = {bus.ch1_chaotic_x, bus.ch0_chaotic_x};
    assign cy   = {bus.ch1_chaotic_y, bus.ch0_chaotic_y};
    assign cz   = {bus.ch1_chaotic_z, bus.ch0_chaotic_z};

    // Only the first valid per channel per attempt is taken, and only in WAIT
    assign take    = (state == WAIT) ? (vld & ~got) : 2'b00;
    assign got_nxt = got | take;

    // Only the period-count MSBs of x carry information
    assign unused_x_lsbs = ^{cx[0][PW-PNW-1:0], cx[1][PW-PNW-1:0]};

    for (genvar n = 0; n < 2; n++) begin : g_ch
        assign der_pn[n] = mods[n] ? cx[n][PW-1 -: PNW] : {PNW{1'b1}};
        assign der_pi[n] = cy[n];
        assign der_pe[n] = mods[n] ? cz[n] : cy[n];
    end

    // Sequencer FSM with registered pulses, buffer capture and output parameter load
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            got                <= '0;
            timer              <= '0;
            to_en              <= 1'b0;
            buf_pn             <= '0;
            buf_pi             <= '0;
            buf_pe             <= '0;
            bus.chaotic_ctrl   <= 1'b0;
            bus.seg_load       <= 1'b0;
            bus.ch0_period_num <= '0;
            bus.ch0_phase_init <= '0;
            bus.ch0_phase_end  <= '0;
            bus.ch1_period_num <= '0;
            bus.ch1_phase_init <= '0;
            bus.ch1_phase_end  <= '0;
            busy               <= 1'b0;
            timeout_err        <= 1'b0;
            seg_count          <= '0;
        end else begin
            bus.chaotic_ctrl <= 1'b0;
            bus.seg_load     <= 1'b0;

            for (int n = 0; n < 2; n++) begin
                if (take[n]) begin
                    buf_pn[n] <= der_pn[n];
                    buf_pi[n] <= der_pi[n];
                    buf_pe[n] <= der_pe[n];
                end
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state            <= REQ;
                        bus.chaotic_ctrl <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                REQ: begin
                    got   <= '0;
                    timer <= timeout_cycles;
                    to_en <= (timeout_cycles != '0);
                    state <= WAIT;
                end
                WAIT: begin
                    got <= got_nxt;
                    // Capture wins over an expiry in the same cycle
                    if (&got_nxt) begin
                        state <= HOLD;
                    end else if (to_en && timer == TIMEOUT_WIDTH'(1)) begin
                        // Partial capture is dropped: REQ clears the got flags
                        timeout_err      <= 1'b1;
                        state            <= REQ;
                        bus.chaotic_ctrl <= 1'b1;
                    end else begin
                        timer <= timer - TIMEOUT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (bus.seg_ready) begin
                        state              <= LOAD;
                        bus.seg_load       <= 1'b1;
                        bus.ch0_period_num <= buf_pn[0];
                        bus.ch0_phase_init <= buf_pi[0];
                        bus.ch0_phase_end  <= buf_pe[0];
                        bus.ch1_period_num <= buf_pn[1];
                        bus.ch1_phase_init <= buf_pi[1];
                        bus.ch1_phase_end  <= buf_pe[1];
                        seg_count          <= seg_count + SEG_CNT_WIDTH'(1);
                    end
                end
                LOAD: begin
                    if (enable) begin
                        state            <= REQ;
                        bus.chaotic_ctrl <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dds_segment_scheduler.sv
// Bench for dds_segment_scheduler: directed and randomized segments checked
// against a transaction-level model of capture, derivation and load timing.
module tb_dds_segment_scheduler;
    localparam int PW  = 32;
    localparam int PNW = 3;
    localparam int TW  = 16;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [TW-1:0] timeout_cycles;
    logic          ch0_mod, ch1_mod;
    logic          busy, timeout_err;
    logic [SW-1:0] seg_count;

    dds_segment_scheduler_if #(.PHASE_WIDTH(PW), .PERIOD_NUM_WIDTH(PNW)) bus ();

    dds_segment_scheduler #(
        .PHASE_WIDTH(PW), .PERIOD_NUM_WIDTH(PNW),
        .TIMEOUT_WIDTH(TW), .SEG_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .timeout_cycles(timeout_cycles),
        .ch0_mod(ch0_mod), .ch1_mod(ch1_mod), .bus(bus),
        .busy(busy), .timeout_err(timeout_err), .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    int nload = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge; outputs are then stable for this cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PNW-1:0] m_pn(input logic m, input logic [PW-1:0] x);
        return m ? PNW'(x >> (PW - PNW)) : {PNW{1'b1}};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic quiet_inputs();
        bus.ch0_chaotic_valid = 1'b0;
        bus.ch1_chaotic_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {bus.chaotic_ctrl, bus.seg_load, busy, timeout_err}, 0);
        chk({tag, "_cnt"}, seg_count, 0);
        chk({tag, "_par"}, |{bus.ch0_period_num, bus.ch0_phase_init, bus.ch0_phase_end,
                            bus.ch1_period_num, bus.ch1_phase_init, bus.ch1_phase_end}, 0);
    endtask

    // One segment: find the iteration pulse, deliver valids d0/d1 cycles later
    // (optional duplicate on CH0 dupk cycles after its first), raise seg_ready
    // r_off cycles after the pulse, then check load timing and loaded values.
    task automatic run_seg(input int d0, input int d1, input int dupk, input int r_off,
                           input bit drop_en,
                           input logic [PW-1:0] x0, input logic [PW-1:0] y0,
                           input logic [PW-1:0] z0, input logic m0,
                           input logic [PW-1:0] x1, input logic [PW-1:0] y1,
                           input logic [PW-1:0] z1, input logic m1,
                           output int c, output int ld);
        int tl, e, extra;
        c = -1;
        ld = -1;
        extra = 0;
        for (int i = 0; i < 40 && c < 0; i++) begin
            if (bus.chaotic_ctrl) c = cyc;
            else tick();
        end
        if (c < 0) begin
            chk("ctrl_wait", 0, 1);
            return;
        end
        bus.seg_ready = 1'b0;
        quiet_inputs();
        tl = imax(d0, d1);
        e  = c + imax(tl + 1, r_off) + 1;
        for (int i = 1; i <= 80 && ld < 0; i++) begin
            tick();
            if (bus.seg_load) ld = cyc;
            if (bus.chaotic_ctrl) extra++;
            bus.ch0_chaotic_valid = (i == d0) || (dupk != 0 && i == d0 + dupk);
            bus.ch0_chaotic_x = (i == d0) ? x0 : $urandom;
            bus.ch0_chaotic_y = (i == d0) ? y0 : $urandom;
            bus.ch0_chaotic_z = (i == d0) ? z0 : $urandom;
            ch0_mod           = (i == d0) ? m0 : 1'($urandom);
            bus.ch1_chaotic_valid = (i == d1);
            bus.ch1_chaotic_x = (i == d1) ? x1 : $urandom;
            bus.ch1_chaotic_y = (i == d1) ? y1 : $urandom;
            bus.ch1_chaotic_z = (i == d1) ? z1 : $urandom;
            ch1_mod           = (i == d1) ? m1 : 1'($urandom);
            bus.seg_ready = (i >= r_off);
            if (drop_en && i == tl + 1) enable = 1'b0;
        end
        quiet_inputs();
        chk("load_cycle", ld, e);
        chk("no_reissue", extra, 0);
        if (ld >= 0) begin
            nload++;
            chk("ch0_pn", bus.ch0_period_num, m_pn(m0, x0));
            chk("ch0_pi", bus.ch0_phase_init, y0);
            chk("ch0_pe", bus.ch0_phase_end, m0 ? z0 : y0);
            chk("ch1_pn", bus.ch1_period_num, m_pn(m1, x1));
            chk("ch1_pi", bus.ch1_phase_init, y1);
            chk("ch1_pe", bus.ch1_phase_end, m1 ? z1 : y1);
            chk("seg_count", seg_count, SW'(nload));
        end
    endtask

    initial begin
        int c, ld, k, prev_ld, tc, extra;
        logic [PW-1:0] xa, ya, za, xb, yb, zb;

        rst = 1'b1;
        enable = 1'b0;
        timeout_cycles = '0;
        ch0_mod = 1'b0;
        ch1_mod = 1'b0;
        bus.seg_ready = 1'b0;
        bus.ch0_chaotic_x = '0; bus.ch0_chaotic_y = '0; bus.ch0_chaotic_z = '0;
        bus.ch1_chaotic_x = '0; bus.ch1_chaotic_y = '0; bus.ch1_chaotic_z = '0;
        quiet_inputs();
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic flow, both channels untruncated
        enable = 1'b1;
        k = cyc;
        tick();
        za = $urandom;
        run_seg(5, 5, 0, 1, 1'b0, 32'hE0000000, 32'h40000000, za, 1'b0,
                32'hE0000000, 32'h40000000, za, 1'b0, c, ld);
        chk("ctrl_latency", c, k + 1);
        prev_ld = ld;

        // Truncation on CH1 only
        tick();
        run_seg(4, 6, 0, 1, 1'b0, 32'h60000000, 32'h11111111, 32'h22222222, 1'b0,
                32'hA0000000, 32'h33333333, 32'h12345678, 1'b1, c, ld);
        chk("ctrl_after_load", c, prev_ld + 1);

        // Staggered valids with a duplicate CH0 valid
        tick();
        run_seg(3, 9, 3, 1, 1'b0, $urandom, $urandom, $urandom, 1'b1,
                $urandom, $urandom, $urandom, 1'b0, c, ld);

        // Backpressure: seg_ready held low 20 cycles after both valids
        tick();
        run_seg(4, 4, 0, 25, 1'b0, $urandom, $urandom, $urandom, 1'b1,
                $urandom, $urandom, $urandom, 1'b1, c, ld);

        // Randomized segments, back to back
        for (int s = 0; s < 30; s++) begin
            tick();
            run_seg($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 5),
                    $urandom_range(1, 15), 1'b0,
                    $urandom, $urandom, $urandom, 1'($urandom),
                    $urandom, $urandom, $urandom, 1'($urandom), c, ld);
        end

        // Drop enable during HOLD: exactly one more load, then idle
        tick();
        run_seg(2, 3, 0, 9, 1'b1, $urandom, $urandom, $urandom, 1'b0,
                $urandom, $urandom, $urandom, 1'b1, c, ld);
        tick();
        chk("drop_busy", busy, 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.seg_load || bus.chaotic_ctrl) extra++;
            tick();
        end
        chk("drop_quiet", extra, 0);

        // Timeout: only CH0 answers within an 8-cycle window
        timeout_cycles = 16'd8;
        enable = 1'b1;
        tick();
        chk("to_ctrl", bus.chaotic_ctrl, 1);
        tc = cyc;
        xa = $urandom; ya = $urandom; za = $urandom;
        extra = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.chaotic_ctrl) extra++;
            bus.ch0_chaotic_valid = (i == 2);
            bus.ch0_chaotic_x = xa; bus.ch0_chaotic_y = ya; bus.ch0_chaotic_z = za;
            ch0_mod = 1'b1;
        end
        quiet_inputs();
        chk("to_no_early", extra, 0);
        chk("to_err_early", timeout_err, 0);
        tick();
        chk("to_reissue_cyc", cyc, tc + 9);
        chk("to_reissue", bus.chaotic_ctrl, 1);
        chk("to_err", timeout_err, 1);
        xb = ~xa; yb = ~ya; zb = ~za;
        run_seg(3, 5, 0, 1, 1'b1, xb, yb, zb, 1'b1,
                $urandom, $urandom, $urandom, 1'b0, c, ld);
        chk("to_err_sticky", timeout_err, 1);

        // timeout_cycles = 0: no valids, wait indefinitely
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nload = 0;
        chk("rst2_err", timeout_err, 0);
        timeout_cycles = '0;
        enable = 1'b1;
        tick();
        chk("nt_ctrl", bus.chaotic_ctrl, 1);
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.chaotic_ctrl || bus.seg_load) extra++;
        end
        chk("nt_no_reissue", extra, 0);
        chk("nt_no_err", timeout_err, 0);
        chk("nt_busy", busy, 1);

        // Reset mid-wait after a partial capture
        bus.ch0_chaotic_valid = 1'b1;
        bus.ch0_chaotic_x = $urandom;
        tick();
        quiet_inputs();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        chk_all_zero("rst_wait");
        rst = 1'b0;
        tick();
        chk("rst_idle", busy, 0);

        // Partial capture must not leak into the next segment
        enable = 1'b1;
        tick();
        run_seg(6, 2, 0, 3, 1'b1, $urandom, $urandom, $urandom, 1'($urandom),
                $urandom, $urandom, $urandom, 1'($urandom), c, ld);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
